// File: rtl/instruction_fetch_unit.sv
// Purpose: hades-V instruction fetch front end. Holds the fetch PC, issues word requests to
//          instruction memory, buffers returned words with their PC in a small FIFO for decode,
//          and flushes/squashes on pipeline redirects.
// Latency: request accept -> response (>=1 cycle) -> instr_valid the cycle after the response.
// Backpressure: requests are credit limited (in-flight + buffered < DEPTH), so a response always
//          has a FIFO slot; instr_ready low simply holds the head entry.
// Ports: clk/rst_n (async active-low); imem_req_* request channel (valid/ready, word address);
//        imem_rsp_* in-order response channel (data + access-fault flag); redirect_valid/pc
//        one-cycle redirect strobe; instr_* decode channel (valid/ready, data, pc, fault flags).
// Option: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect to a non-word-aligned target issues
//        no request and delivers one misaligned-fault entry; otherwise the target is aligned down.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_error,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        instr_fault,
   output logic        instr_misaligned
);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef enum logic {RUN, HALT} mode_e;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        fault;
      logic        misaligned;
   } entry_t;

   mode_e         mode_q, mode_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] stale_q, stale_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   entry_t        fifo_q [DEPTH];

   entry_t        head;
   entry_t        push_entry;
   logic [AW-1:0] push_idx;
   logic          push, pop;
   logic          req_ok, req_fire;
   logic          mis_redirect;
   logic [31:0]   target_pc, rsp_pc;
   logic [CW:0]   credits_used;

   always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_redirect = (redirect_pc[1:0] != 2'b00);
      target_pc    = redirect_pc;
`else
      mis_redirect = 1'b0;
      target_pc    = {redirect_pc[31:2], 2'b00};
`endif
   end

   // Head leaving this cycle returns its credit immediately, which is what allows
   // one instruction per cycle with DEPTH=2 and single-cycle memory.
   assign pop          = instr_valid && instr_ready && !redirect_valid;
   assign credits_used = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
   assign req_ok       = (mode_q == RUN) && !redirect_valid && (credits_used < DEPTH_C);
   assign req_fire     = req_ok && imem_req_ready;
   // rst_n only masks the visible request; state is held in reset anyway.
   assign imem_req_valid = req_ok && rst_n;
   assign imem_req_addr  = pc_q;

   // Responses are in order and non-stale requests are contiguous up to pc_q,
   // so the oldest live request sits out_q words behind the fetch PC.
   assign rsp_pc = pc_q - (32'(out_q) << 2);

   always_comb begin
      mode_d     = mode_q;
      pc_d       = pc_q;
      out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      stale_d    = stale_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      push       = 1'b0;
      push_idx   = wr_q;
      push_entry = '0;

      if (req_fire) begin
         pc_d = pc_q + 32'd4;
      end

      if (redirect_valid) begin
         // No request can fire this cycle, so everything still in flight is stale.
         stale_d = out_q - CW'(imem_rsp_valid);
         pc_d    = target_pc;
         mode_d  = RUN;
         cnt_d   = '0;
         wr_d    = '0;
         rd_d    = '0;
         if (mis_redirect) begin
            push       = 1'b1;
            push_idx   = '0;
            push_entry = '{data: NOP, pc: redirect_pc, fault: 1'b0, misaligned: 1'b1};
            mode_d     = HALT;
            cnt_d      = CW'(1);
            wr_d       = AW'(1);
         end
      end else begin
         if (imem_rsp_valid) begin
            if (stale_q != '0) begin
               stale_d = stale_q - CW'(1);
            end else if (mode_q == RUN) begin
               push = 1'b1;
               if (imem_rsp_error) begin
                  push_entry = '{data: NOP, pc: rsp_pc, fault: 1'b1, misaligned: 1'b0};
                  mode_d     = HALT;
               end else begin
                  push_entry = '{data: imem_rsp_data, pc: rsp_pc, fault: 1'b0, misaligned: 1'b0};
               end
            end
         end
         if (push) wr_d = wr_q + AW'(1);
         if (pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= RUN;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         stale_q <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         mode_q  <= mode_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         stale_q <= stale_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         if (push) fifo_q[push_idx] <= push_entry;
      end
   end

   // Outputs come straight from FIFO storage (no bypass) and read as zero when empty.
   assign head             = fifo_q[rd_q];
   assign instr_valid      = (cnt_q != '0);
   assign instr_data       = instr_valid ? head.data  : 32'h0;
   assign instr_pc         = instr_valid ? head.pc    : 32'h0;
   assign instr_fault      = instr_valid && head.fault;
   // Only the misaligned-redirect path ever stores this flag, so it stays 0 without the option.
   assign instr_misaligned = instr_valid && head.misaligned;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid, imem_rsp_error;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready, instr_fault, instr_misaligned;
   logic [31:0] instr_data, instr_pc;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_error(imem_rsp_error),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .instr_pc(instr_pc), .instr_fault(instr_fault), .instr_misaligned(instr_misaligned)
   );

   typedef struct { logic [31:0] data; logic [31:0] pc; logic fault; logic mis; } exp_t;
   typedef struct { logic [31:0] addr; int due; } req_t;

   exp_t exp_q[$];     // expected decode stream of the current fetch epoch
   req_t pend_q[$];    // memory model: accepted requests awaiting response

   int checks = 0, errors = 0;
   int cyc = 0, phase = 0, hs_count = 0, pop_count = 0;
   logic [31:0] gen_addr = 32'h0, req_next = 32'h0;
   logic gen_done = 1'b0, req_none = 1'b0;
   logic prev_redir = 1'b0, prev_redir_mis = 1'b0;

   // Memory contents: data and access faults are pure functions of the address.
   function automatic logic mem_err(input logic [31:0] a);
      logic [31:0] h;
      h = a ^ (a >> 7);
      return (h & 32'h0000_00FC) == 32'h0000_00B4;
   endfunction

   function automatic logic [31:0] mem_dat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Next element of the straight-line fetch stream; a faulting word ends the epoch.
   task automatic gen_push();
      exp_t e;
      if (gen_done) return;
      e.pc = gen_addr;
      e.mis = 1'b0;
      if (mem_err(gen_addr)) begin
         e.data = NOP; e.fault = 1'b1; gen_done = 1'b1;
      end else begin
         e.data = mem_dat(gen_addr); e.fault = 1'b0; gen_addr = gen_addr + 32'd4;
      end
      exp_q.push_back(e);
   endtask

   task automatic start_epoch(input logic [31:0] t);
      exp_t e;
      exp_q.delete();
      gen_done = 1'b0;
      req_none = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (t[1:0] != 2'b00) begin
         e.data = NOP; e.pc = t; e.fault = 1'b0; e.mis = 1'b1;
         exp_q.push_back(e);
         gen_done = 1'b1;
         req_none = 1'b1;
         return;
      end
`endif
      gen_addr = {t[31:2], 2'b00};
      req_next = gen_addr;
      for (int i = 0; i < 4; i++) gen_push();
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      start_epoch(t);
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      case ($urandom_range(0, 7))
         0:       t = 32'hFFFF_FFF4;
         1:       t = 32'h0000_0040;
         default: t = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
      endcase
      if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      redirect_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && (phase != 3 || $urandom_range(0, 3) != 0)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_dat(pend_q[0].addr);
         imem_rsp_error = mem_err(pend_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
         imem_rsp_error = 1'b0;
      end
   endtask

   // Request/response observer: memory bookkeeping plus request-side rules.
   always @(negedge clk) begin
      if (rst_n) begin
         int   inflight;
         req_t r;
         logic mis_now;
         inflight = pend_q.size();
`ifdef FETCH_MISALIGN_CHECK_EN
         mis_now = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
         mis_now = 1'b0;
`endif
         if (redirect_valid) chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
         if (prev_redir && !prev_redir_mis) chk("instr_valid_after_redirect", 32'(instr_valid), 32'd0);
         if (phase == 1 && cyc <= 9) chk("stream_req_valid", 32'(imem_req_valid), 32'd1);
         if (phase == 1 && cyc >= 2 && cyc <= 9) chk("stream_instr_valid", 32'(instr_valid), 32'd1);
         if (imem_req_valid && imem_req_ready) begin
            chk("req_credit", 32'(inflight < DEPTH), 32'd1);
            if (req_none) begin
               chk("req_while_misaligned_halt", 32'(imem_req_valid), 32'd0);
            end else begin
               chk("req_addr", imem_req_addr, req_next);
               req_next = req_next + 32'd4;
            end
            r.addr = imem_req_addr;
            r.due  = cyc + ((phase == 3) ? int'($urandom_range(1, 3)) : 1);
            pend_q.push_back(r);
            hs_count++;
         end
         if (imem_rsp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
         prev_redir     = redirect_valid;
         prev_redir_mis = mis_now;
      end
   end

   // Decode-side monitor: every consumed entry is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc %h data %h, no entry expected (cycle %0d)", instr_pc, instr_data, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr_data", instr_data, e.data);
            chk("instr_fault", 32'(instr_fault), 32'(e.fault));
            chk("instr_misaligned", 32'(instr_misaligned), 32'(e.mis));
            gen_push();
            pop_count++;
         end
      end
   end

   initial begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_error = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
      start_epoch(RST_PC);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_instr_valid", 32'(instr_valid), 32'd0);
      chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
      chk("reset_instr_data", instr_data, 32'h0);
      chk("reset_instr_pc", instr_pc, 32'h0);
      chk("reset_fault_flags", {30'h0, instr_fault, instr_misaligned}, 32'h0);

      // Streaming: single-cycle memory, decode always ready.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      phase = 1;
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      repeat (11) step();

      // Redirect with requests in flight, then decode stall: only DEPTH new requests.
      step();
      phase = 2;
      instr_ready = 1'b0;
      do_redirect(32'h0000_2000);
      hs_count = 0;
      repeat (10) begin
         step();
         instr_ready = 1'b0;
      end
      chk("stall_req_count", 32'(hs_count), 32'd2);
      step();
      instr_ready = 1'b1;
      hs_count = 0;
      repeat (6) begin
         step();
         instr_ready = 1'b0;
      end
      chk("after_pop_req_count", 32'(hs_count), 32'd1);

      // Randomised traffic, starting with an address wrap.
      step();
      phase = 3;
      do_redirect(32'hFFFF_FFF8);
      repeat (3000) begin
         step();
         imem_req_ready = ($urandom_range(0, 3) != 0);
         instr_ready    = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 39) == 0) do_redirect(rand_target());
      end
      step();
      @(negedge clk);
      chk("progress", 32'(pop_count > 100), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
